// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type and address-geometry helpers for the set-associative cache
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESPOND} state_t;
  function automatic int off_w(int line_w);
    return $clog2(line_w / 8);
  endfunction
  function automatic int idx_w(int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(int addr_w, int line_w, int sets);
    return addr_w - off_w(line_w) - idx_w(sets);
  endfunction
  function automatic int word_lsb(int byte_off, int data_w);
    return (byte_off / (data_w / 8)) * data_w;
  endfunction
endpackage

// File: rtl/cache_way_ram.sv
// cache_way_ram: one way's tag and data arrays, synchronous read, single line-or-word write port
module cache_way_ram
  import cache_pkg::*;
#(
  parameter int TAG_W = 17,
  parameter int LINE_W = 128,
  parameter int DATA_W = 32,
  parameter int SETS = 64,
  localparam int IDX_W = idx_w(SETS),
  localparam int OFF_W = off_w(LINE_W)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              we,
  input  logic              we_line,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_word,
  input  logic [LINE_W-1:0] wr_line
);
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];
  always_ff @(posedge clk) begin
    if (re) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_line <= data_mem[rd_idx];
    end
    if (we && we_line) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end else if (we) begin
      data_mem[wr_idx][word_lsb(int'(wr_off), DATA_W) +: DATA_W] <= wr_word;
    end
  end
endmodule

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: N-way set-associative write-back/write-allocate cache controller with hit/miss counters
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              memory_sig,
  input  logic              read_or_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              finish,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int OFF_W = off_w(LINE_W);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WB = WAYS > 1 ? $clog2(WAYS) : 1;
  state_t state, nxt;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata, fill_word;
  logic req_rd, hit, found;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  int lsb;
  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [SETS-1:0][WB-1:0] rr_q;
  logic [WB-1:0] victim_q, victim, hit_way;
  logic [WAYS-1:0] way_we;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];
  assign idx = req_addr[OFF_W +: IDX_W];
  assign tag = req_addr[ADDR_W-1 -: TAG_W];
  assign lsb = word_lsb(int'(req_addr[OFF_W-1:0]), DATA_W);
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign way_we[g] = ((victim_q == WB'(g)) && ((state == FILL_WAIT && mem_resp_valid) || (state == RESPOND && !req_rd)))
                    || (state == LOOKUP && hit && !req_rd && hit_way == WB'(g));
    cache_way_ram #(.TAG_W(TAG_W), .LINE_W(LINE_W), .DATA_W(DATA_W), .SETS(SETS)) u_ram (
      .clk     (clk),
      .re      (state == IDLE && memory_sig),
      .rd_idx  (addr[OFF_W +: IDX_W]),
      .rd_tag  (way_tag[g]),
      .rd_line (way_line[g]),
      .we      (way_we[g]),
      .we_line (state == FILL_WAIT),
      .wr_idx  (idx),
      .wr_tag  (tag),
      .wr_off  (req_addr[OFF_W-1:0]),
      .wr_word (req_wdata),
      .wr_line (mem_resp_rdata)
    );
  end
  // lowest invalid way is preferred as victim; otherwise the set's round-robin pointer
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    found = 1'b0;
    victim = rr_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && way_tag[w] == tag) begin
        hit = 1'b1;
        hit_way = WB'(w);
      end
      if (!found && !valid_q[idx][w]) begin
        found = 1'b1;
        victim = WB'(w);
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = memory_sig ? LOOKUP : IDLE;
      LOOKUP:    nxt = hit ? IDLE : (dirty_q[idx][victim] ? WB_REQ : FILL_REQ);
      WB_REQ:    nxt = mem_req_ready ? FILL_REQ : WB_REQ;
      FILL_REQ:  nxt = mem_req_ready ? FILL_WAIT : FILL_REQ;
      FILL_WAIT: nxt = mem_resp_valid ? RESPOND : FILL_WAIT;
      default:   nxt = IDLE;
    endcase
  end
  assign mem_req_valid = state == WB_REQ || state == FILL_REQ;
  assign mem_req_we = state == WB_REQ;
  assign mem_req_addr = state == WB_REQ ? {way_tag[victim_q], idx, {OFF_W{1'b0}}}
                      : state == FILL_REQ ? {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_req_wdata = state == WB_REQ ? way_line[victim_q] : '0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      finish <= 1'b0;
      read_data <= '0;
      hit_count <= '0;
      miss_count <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      rr_q <= '0;
      victim_q <= '0;
      req_addr <= '0;
      req_wdata <= '0;
      req_rd <= 1'b0;
      fill_word <= '0;
    end else begin
      state <= nxt;
      finish <= 1'b0;
      if (state == IDLE && memory_sig) begin
        req_addr <= addr;
        req_wdata <= write_data;
        req_rd <= read_or_write;
      end
      if (state == LOOKUP && hit) begin
        finish <= 1'b1;
        hit_count <= hit_count + {31'd0, ~&hit_count};
        if (req_rd) read_data <= way_line[hit_way][lsb +: DATA_W];
        else dirty_q[idx][hit_way] <= 1'b1;
      end
      if (state == LOOKUP && !hit) begin
        miss_count <= miss_count + {31'd0, ~&miss_count};
        victim_q <= victim;
      end
      if (state == FILL_WAIT && mem_resp_valid) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
        fill_word <= mem_resp_rdata[lsb +: DATA_W];
        if (WAYS > 1) rr_q[idx] <= rr_q[idx] + WB'(1);
      end
      if (state == RESPOND) begin
        finish <= 1'b1;
        if (req_rd) read_data <= fill_word;
        else dirty_q[idx][victim_q] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb_assoc_cache_ctrl: table-driven scoreboard bench for assoc_cache_ctrl with a line-granular memory responder
module tb_assoc_cache_ctrl;
  logic clk = 1'b0, rstn = 1'b0, memory_sig = 1'b0, read_or_write = 1'b1;
  logic [26:0] addr = '0;
  logic [31:0] write_data = '0, read_data;
  logic finish, mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [26:0] mem_req_addr;
  logic [127:0] mem_req_wdata, mem_resp_rdata;
  logic [31:0] hit_count, miss_count;
  always #5 clk = ~clk;

  assoc_cache_ctrl dut (
    .clk(clk), .rstn(rstn), .memory_sig(memory_sig), .read_or_write(read_or_write),
    .addr(addr), .write_data(write_data), .read_data(read_data), .finish(finish),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0, fails = 0, fin_total = 0, exp_hit = 0, exp_miss = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] wmem [logic [26:0]];
  logic [127:0] bmem [logic [26:0]];
  function automatic logic [31:0] pat(input logic [26:0] a);
    return 32'hC0DE_0000 ^ {5'd0, a};
  endfunction
  function automatic logic [31:0] exp_word(input logic [26:0] a);
    logic [26:0] al = {a[26:2], 2'b00};
    return wmem.exists(al) ? wmem[al] : pat(al);
  endfunction
  function automatic logic [127:0] model_line(input logic [26:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = exp_word(la + 27'(i * 4));
    return l;
  endfunction
  function automatic logic [127:0] bline(input logic [26:0] la);
    logic [127:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = pat(la + 27'(i * 4));
    return l;
  endfunction

  typedef struct {logic we; logic [26:0] a; logic [127:0] d;} req_t;
  typedef struct {logic rd; logic [31:0] d;} exp_t;
  req_t rlog[$];
  exp_t sbq[$];

  int stall_left = 0, resp_delay = 0, resp_wait = 0, stall_bad = 0;
  logic resp_due = 1'b0, snap_v = 1'b0, snap_we;
  logic [26:0] snap_a, fill_a;
  initial begin
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      if (resp_due) begin
        if (resp_wait == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = bline(fill_a);
          resp_due = 1'b0;
        end else resp_wait--;
      end else if (mem_req_valid) begin
        if (stall_left > 0) begin
          if (!snap_v) begin
            snap_v = 1'b1;
            snap_we = mem_req_we;
            snap_a = mem_req_addr;
          end else if (mem_req_we !== snap_we || mem_req_addr !== snap_a) stall_bad++;
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          snap_v = 1'b0;
          rlog.push_back('{mem_req_we, mem_req_addr, mem_req_wdata});
          if (mem_req_we) bmem[mem_req_addr] = mem_req_wdata;
          else begin
            resp_due = 1'b1;
            resp_wait = resp_delay;
            fill_a = mem_req_addr;
          end
        end
      end else if (snap_v && stall_left > 0) stall_bad++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && finish) begin
        fin_total++;
        if (sbq.size() == 0) chk("spurious_finish", finish, 1'b0);
        else begin
          e = sbq.pop_front();
          if (e.rd) chk("read_data", read_data, e.d);
        end
      end
    end
  end

  task automatic access(input logic rd, input logic [26:0] a, input logic [31:0] wd, input int exp_lat, input logic noisy);
    int n = 0;
    logic [26:0] al = {a[26:2], 2'b00};
    sbq.push_back('{rd, rd ? exp_word(al) : wd});
    if (!rd) wmem[al] = wd;
    @(negedge clk);
    memory_sig = 1'b1;
    read_or_write = rd;
    addr = a;
    write_data = wd;
    do begin
      @(negedge clk);
      n++;
      if (!noisy) memory_sig = 1'b0;
      else begin
        addr = 27'($urandom);
        write_data = $urandom;
        read_or_write = 1'($urandom);
      end
    end while (!finish && n < 200);
    memory_sig = 1'b0;
    chk("latency", n, exp_lat);
  endtask

  typedef struct {logic rd; logic [26:0] a; logic [31:0] wd; logic miss; logic wb; logic [26:0] wba;} vec_t;
  vec_t tbl [17];

  initial begin
    int r0, f0, n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, f0, n;
    tbl[0]  = '{1, 27'h100, 32'h0, 1, 0, 27'h0};
    tbl[1]  = '{1, 27'h100, 32'h0, 0, 0, 27'h0};
    tbl[2]  = '{0, 27'h104, 32'hDEADBEEF, 0, 0, 27'h0};
    tbl[3]  = '{1, 27'h104, 32'h0, 0, 0, 27'h0};
    tbl[4]  = '{1, 27'h000, 32'h0, 1, 0, 27'h0};
    tbl[5]  = '{1, 27'h400, 32'h0, 1, 0, 27'h0};
    tbl[6]  = '{0, 27'h008, 32'h12345678, 0, 0, 27'h0};
    tbl[7]  = '{1, 27'h800, 32'h0, 1, 1, 27'h000};
    tbl[8]  = '{1, 27'h008, 32'h0, 1, 0, 27'h0};
    tbl[9]  = '{1, 27'h400, 32'h0, 1, 0, 27'h0};
    tbl[10] = '{0, 27'h80C, 32'hAAAA5555, 1, 0, 27'h0};
    tbl[11] = '{1, 27'h80C, 32'h0, 0, 0, 27'h0};
    tbl[12] = '{1, 27'h000, 32'h0, 1, 0, 27'h0};
    tbl[13] = '{1, 27'h400, 32'h0, 1, 1, 27'h800};
    tbl[14] = '{1, 27'h80C, 32'h0, 1, 0, 27'h0};
    tbl[15] = '{0, 27'h1F0, 32'h0BADF00D, 1, 0, 27'h0};
    tbl[16] = '{1, 27'h1F0, 32'h0, 0, 0, 27'h0};
    #1;
    chk("rst_finish", finish, 1'b0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_req_we", mem_req_we, 1'b0);
    chk("rst_req_addr", mem_req_addr, 27'h0);
    chk("rst_req_wdata", mem_req_wdata, 128'h0);
    chk("rst_hit_count", hit_count, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      r0 = rlog.size();
      access(tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].miss ? (tbl[i].wb ? 6 : 5) : 2, 1'b0);
      if (tbl[i].miss) exp_miss++;
      else exp_hit++;
      chk($sformatf("hit_count[%0d]", i), hit_count, exp_hit);
      chk($sformatf("miss_count[%0d]", i), miss_count, exp_miss);
      chk($sformatf("req_count[%0d]", i), rlog.size() - r0, int'(tbl[i].miss) + int'(tbl[i].wb));
      if (tbl[i].wb && rlog.size() > r0) begin
        chk($sformatf("wb_we[%0d]", i), rlog[r0].we, 1'b1);
        chk($sformatf("wb_addr[%0d]", i), rlog[r0].a, tbl[i].wba);
        chk($sformatf("wb_data[%0d]", i), rlog[r0].d, model_line(tbl[i].wba));
      end
      if (tbl[i].miss && rlog.size() > r0) begin
        chk($sformatf("fill_we[%0d]", i), rlog[rlog.size()-1].we, 1'b0);
        chk($sformatf("fill_addr[%0d]", i), rlog[rlog.size()-1].a, {tbl[i].a[26:4], 4'h0});
      end
    end

    r0 = rlog.size();
    stall_left = 10;
    access(1'b1, 27'h2050, 32'h0, 15, 1'b0);
    exp_miss++;
    chk("stall_stable", stall_bad, 0);
    chk("stall_one_request", rlog.size() - r0, 1);
    chk("stall_miss_count", miss_count, exp_miss);

    f0 = fin_total;
    resp_delay = 3;
    access(1'b1, 27'h3060, 32'h0, 8, 1'b1);
    access(1'b1, 27'h3064, 32'h0, 2, 1'b1);
    exp_miss++;
    exp_hit++;
    repeat (6) @(negedge clk);
    chk("noise_finish_count", fin_total - f0, 2);
    chk("noise_hit_count", hit_count, exp_hit);
    chk("noise_miss_count", miss_count, exp_miss);

    resp_delay = 6;
    r0 = rlog.size();
    @(negedge clk);
    memory_sig = 1'b1;
    read_or_write = 1'b1;
    addr = 27'h4070;
    sbq.push_back('{1'b1, exp_word(27'h4070)});
    @(negedge clk);
    memory_sig = 1'b0;
    n = 0;
    while (rlog.size() == r0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_fill_issued", rlog.size() - r0, 1);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_req_valid", mem_req_valid, 1'b0);
    chk("midrst_finish", finish, 1'b0);
    chk("midrst_read_data", read_data, 32'h0);
    chk("midrst_hit_count", hit_count, 32'h0);
    chk("midrst_miss_count", miss_count, 32'h0);
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("stray_resp_miss_count", miss_count, 32'h0);
    resp_delay = 0;
    exp_hit = 0;
    exp_miss = 1;
    r0 = rlog.size();
    access(1'b1, 27'h4070, 32'h0, 5, 1'b0);
    chk("postrst_miss_count", miss_count, exp_miss);
    chk("postrst_hit_count", hit_count, exp_hit);
    chk("postrst_fill_request", rlog.size() - r0, 1);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
